// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite command master.
// State encoding, response codes and a constant clog2.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(
    input longint unsigned value
  );
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Per-transaction timeout counter.
// Saturates at its limit so it never wraps; limit 0 disables expiry.
module axi_lite_timeout_ctr
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW_RAW = clog2(C_TIMEOUT_CYCLES + 1);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam bit EN = (C_TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT =
    EN ? CW'(C_TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LIMIT);
  assign o_expired  = EN && w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master: one single-beat transaction per command,
// with timeout abort and drain of a late B/R response.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_LITE_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_LITE_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES        = 1024,
  parameter logic [2:0]  C_PROT                  = 3'b000
) (
  input  logic M_AXI_LITE_ACLK,
  input  logic M_AXI_LITE_ARESETN,

  input  logic CMD_VALID,
  output logic CMD_READY,
  input  logic CMD_WRITE,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0] CMD_WDATA,
  input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] CMD_WSTRB,

  output logic RSP_VALID,
  input  logic RSP_READY,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0] RSP_RESP,
  output logic RSP_TIMEOUT,
  output logic BUSY,

  output logic M_AXI_LITE_AWVALID,
  input  logic M_AXI_LITE_AWREADY,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0] M_AXI_LITE_AWADDR,
  output logic [2:0] M_AXI_LITE_AWPROT,

  output logic M_AXI_LITE_WVALID,
  input  logic M_AXI_LITE_WREADY,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0] M_AXI_LITE_WDATA,
  output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] M_AXI_LITE_WSTRB,

  input  logic M_AXI_LITE_BVALID,
  output logic M_AXI_LITE_BREADY,
  input  logic [1:0] M_AXI_LITE_BRESP,

  output logic M_AXI_LITE_ARVALID,
  input  logic M_AXI_LITE_ARREADY,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0] M_AXI_LITE_ARADDR,
  output logic [2:0] M_AXI_LITE_ARPROT,

  input  logic M_AXI_LITE_RVALID,
  output logic M_AXI_LITE_RREADY,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0] M_AXI_LITE_RDATA,
  input  logic [1:0] M_AXI_LITE_RRESP
);

  localparam int AW = C_M_AXI_LITE_ADDR_WIDTH;
  localparam int DW = C_M_AXI_LITE_DATA_WIDTH;
  localparam int SW = DW / 8;

  state_t r_state;
  state_t w_next;

  logic          r_cmd_ready;
  logic          r_awvalid;
  logic          r_wvalid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_resp;
  logic          r_timeout;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_aw_pend;
  logic w_w_pend;
  logic w_bready;
  logic w_rready;
  logic w_arvalid;
  logic w_active;
  logic w_expired;
  logic w_tmo;

  assign w_accept  = CMD_VALID & r_cmd_ready;
  assign w_arvalid = (r_state == ST_RD_REQ);
  assign w_bready  = (r_state == ST_WR_RESP) |
                     (r_state == ST_DRAIN);
  assign w_rready  = (r_state == ST_RD_RESP) |
                     (r_state == ST_DRAIN);

  assign w_aw_hs   = r_awvalid & M_AXI_LITE_AWREADY;
  assign w_w_hs    = r_wvalid  & M_AXI_LITE_WREADY;
  assign w_ar_hs   = w_arvalid & M_AXI_LITE_ARREADY;
  assign w_b_hs    = w_bready  & M_AXI_LITE_BVALID;
  assign w_r_hs    = w_rready  & M_AXI_LITE_RVALID;
  assign w_aw_pend = r_awvalid & ~M_AXI_LITE_AWREADY;
  assign w_w_pend  = r_wvalid  & ~M_AXI_LITE_WREADY;

  assign w_active  = (r_state == ST_WR_REQ)  |
                     (r_state == ST_WR_RESP) |
                     (r_state == ST_RD_REQ)  |
                     (r_state == ST_RD_RESP);

  // A B/R handshake on the expiry cycle beats the timeout.
  assign w_tmo = w_expired & w_active & ~(w_b_hs | w_r_hs);

  axi_lite_timeout_ctr #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (M_AXI_LITE_ACLK),
    .rst_n    (M_AXI_LITE_ARESETN),
    .i_clear  (w_accept),
    .i_enable (w_active),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_next = CMD_WRITE ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (w_tmo)
          w_next = ST_RSP;
        else if (!w_aw_pend && !w_w_pend)
          w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (w_b_hs || w_tmo) w_next = ST_RSP;
      end
      ST_RD_REQ: begin
        if (w_tmo)
          w_next = ST_RSP;
        else if (w_ar_hs)
          w_next = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (w_r_hs || w_tmo) w_next = ST_RSP;
      end
      ST_RSP: begin
        if (RSP_READY)
          w_next = r_timeout ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_b_hs || w_r_hs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_LITE_ACLK or negedge M_AXI_LITE_ARESETN) begin
    if (!M_AXI_LITE_ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge M_AXI_LITE_ACLK or negedge M_AXI_LITE_ARESETN) begin
    if (!M_AXI_LITE_ARESETN) begin
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_resp      <= RESP_OKAY;
      r_timeout   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_addr    <= CMD_ADDR;
        r_wdata   <= CMD_WDATA;
        r_wstrb   <= CMD_WSTRB;
        r_awvalid <= CMD_WRITE;
        r_wvalid  <= CMD_WRITE;
      end else begin
        if (w_aw_hs || w_tmo) r_awvalid <= 1'b0;
        if (w_w_hs  || w_tmo) r_wvalid  <= 1'b0;
      end
      if (w_b_hs && (r_state == ST_WR_RESP)) begin
        r_rdata   <= '0;
        r_resp    <= M_AXI_LITE_BRESP;
        r_timeout <= 1'b0;
      end else if (w_r_hs && (r_state == ST_RD_RESP)) begin
        r_rdata   <= M_AXI_LITE_RDATA;
        r_resp    <= M_AXI_LITE_RRESP;
        r_timeout <= 1'b0;
      end else if (w_tmo) begin
        r_rdata   <= '0;
        r_resp    <= RESP_SLVERR;
        r_timeout <= 1'b1;
      end
    end
  end

  assign CMD_READY          = r_cmd_ready;
  assign RSP_VALID          = (r_state == ST_RSP);
  assign RSP_RDATA          = r_rdata;
  assign RSP_RESP           = r_resp;
  assign RSP_TIMEOUT        = r_timeout;
  assign BUSY               = (r_state != ST_IDLE);

  assign M_AXI_LITE_AWVALID = r_awvalid;
  assign M_AXI_LITE_AWADDR  = r_addr;
  assign M_AXI_LITE_AWPROT  = C_PROT;
  assign M_AXI_LITE_WVALID  = r_wvalid;
  assign M_AXI_LITE_WDATA   = r_wdata;
  assign M_AXI_LITE_WSTRB   = r_wstrb;
  assign M_AXI_LITE_BREADY  = w_bready;
  assign M_AXI_LITE_ARVALID = w_arvalid;
  assign M_AXI_LITE_ARADDR  = r_addr;
  assign M_AXI_LITE_ARPROT  = C_PROT;
  assign M_AXI_LITE_RREADY  = w_rready;

endmodule
